if_stage: RTL and testbench



---
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// loads IF/ID, redirecting and squashing the wrong path on a taken branch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_Taken,
    input  logic [31:0] Br_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_buf;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_redirect;

    // Branch target is relative to PC+4 of the branch sitting in IF/ID.
    assign w_target   = r_if_id_pc + (Br_offset << 2);
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_redirect = Branch_Taken & ~freeze;

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_req         <= 1'b1;
            r_pc          <= RESET_PC;
            r_tgt         <= 32'd0;
            r_buf         <= 32'd0;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_if_id_pc    <= 32'd0;
                        r_if_id_instr <= 32'd0;
                        r_if_id_valid <= 1'b0;
                        if (imem_ready) begin
                            r_pc <= w_target;
                        end else begin
                            // Request is still in flight; keep the address and wait it out.
                            r_tgt   <= w_target;
                            r_state <= S_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (!freeze) begin
                            r_if_id_pc    <= w_pc_inc;
                            r_if_id_instr <= imem_rdata;
                            r_if_id_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_req   <= 1'b0;
                            r_state <= S_HOLD;
                        end
                    end else if (!freeze) begin
                        r_if_id_instr <= 32'd0;
                        r_if_id_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (!freeze) begin
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                        if (Branch_Taken) begin
                            r_if_id_pc    <= 32'd0;
                            r_if_id_instr <= 32'd0;
                            r_if_id_valid <= 1'b0;
                            r_pc          <= w_target;
                        end else begin
                            r_if_id_pc    <= w_pc_inc;
                            r_if_id_instr <= r_buf;
                            r_if_id_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_redirect) begin
                        r_tgt         <= w_target;
                        r_if_id_pc    <= 32'd0;
                        r_if_id_instr <= 32'd0;
                        r_if_id_valid <= 1'b0;
                    end
                    // Wrong-path data is dropped; the most recent redirect wins.
                    if (imem_ready) begin
                        r_pc    <= w_redirect ? w_target : r_tgt;
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stalls, memory wait states
// and branches, checked against a program-order fetch-stream scoreboard.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Branch_Taken;
    logic [31:0] Br_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    logic        rdy_en;
    int          n_checks;
    int          n_fail;
    int          n_deliv;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_next;
    logic [31:0] last_pc4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_Taken (Branch_Taken),
        .Br_offset    (Br_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    // Memory: data is a fixed function of the address; ready only while requested.
    assign imem_rdata = instr_of(imem_addr);
    assign imem_ready = rdy_en & imem_req & ~rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected fetch stream in program order from exp_next.
    task automatic top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc4: exp_next + 32'd4, instr: instr_of(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_next = RESET_PC;
        last_pc4 = 32'd0;
        top_up();
    endtask

    // Drive one cycle of inputs at a negedge; a taken, unfrozen branch restarts the stream.
    task automatic step(input logic bt, input logic [31:0] off, input logic frz, input logic rdy);
        Branch_Taken = bt;
        Br_offset    = off;
        freeze       = frz;
        rdy_en       = rdy;
        if (bt && !frz) begin
            exp_q.delete();
            exp_next = last_pc4 + (off << 2);
        end
        top_up();
        @(negedge clk);
    endtask

    // Monitor: every newly loaded valid IF/ID entry must be the next in program order.
    initial begin
        logic        s_frz;
        logic        s_rst;
        logic        s_wait;
        logic [31:0] s_addr;
        exp_t        e;
        forever begin
            @(posedge clk);
            s_frz  = freeze;
            s_rst  = rst;
            s_addr = imem_addr;
            s_wait = imem_req & ~imem_ready;
            #1;
            if (!s_rst && !rst) begin
                if (s_wait)
                    check("addr_stable_while_waiting", imem_addr, s_addr);
                if (!s_frz && if_id_valid) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_empty: got pc %h with no expected entry", if_id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", if_id_pc, e.pc4);
                        check("sb_instr", if_id_instr, e.instr);
                        last_pc4 = e.pc4;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        logic bt;
        n_checks = 0;
        n_fail   = 0;
        n_deliv  = 0;
        rst = 1'b1;
        freeze = 1'b0;
        Branch_Taken = 1'b0;
        Br_offset = 32'd0;
        rdy_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        rst = 1'b0;

        // Zero-wait sequential fetch
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("seq_pc1", if_id_pc, 32'd4);
        check("seq_valid1", 32'(if_id_valid), 32'd1);
        check("seq_addr1", imem_addr, 32'd4);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("seq_addr2", imem_addr, 32'd8);

        // Freeze with ready: capture instr@8, stop requesting, IF/ID constant
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_pc", if_id_pc, 32'd8);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("hold_pc3", if_id_pc, 32'd8);
        check("hold_instr3", if_id_instr, instr_of(32'd4));
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("release_pc", if_id_pc, 32'd12);
        check("release_instr", if_id_instr, instr_of(32'd8));
        check("release_addr", imem_addr, 32'd12);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("pre_branch_pc", if_id_pc, 32'h14);

        // Backward branch with zero-wait memory: one bubble
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        check("br_addr", imem_addr, 32'h0C);
        check("br_bubble", 32'(if_id_valid), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("br_tgt_pc", if_id_pc, 32'h10);
        check("br_tgt_instr", if_id_instr, instr_of(32'h0C));

        // Redirect to 0x40 while the request at 0x10 waits
        step(1'b1, 32'h0000_000C, 1'b0, 1'b0);
        check("drain_addr1", imem_addr, 32'h10);
        check("drain_valid1", 32'(if_id_valid), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("drain_addr2", imem_addr, 32'h10);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("drain_next_addr", imem_addr, 32'h40);
        check("drain_valid3", 32'(if_id_valid), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("drain_valid4", 32'(if_id_valid), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("drain_tgt_pc", if_id_pc, 32'h44);

        // Taken branch ignored under freeze, honoured on release
        step(1'b1, 32'h0000_0010, 1'b1, 1'b1);
        check("frz_br_req", 32'(imem_req), 32'd0);
        check("frz_br_pc", if_id_pc, 32'h44);
        step(1'b1, 32'h0000_0010, 1'b1, 1'b1);
        check("frz_br_addr", imem_addr, 32'h44);
        step(1'b1, 32'h0000_0010, 1'b0, 1'b1);
        check("frz_br_redirect", imem_addr, 32'h84);
        check("frz_br_bubble", 32'(if_id_valid), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("frz_br_tgt_pc", if_id_pc, 32'h88);

        // Reset in the middle of a drain
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_addr", imem_addr, RESET_PC);
        check("mid_rst_valid", 32'(if_id_valid), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("post_rst_pc", if_id_pc, RESET_PC + 32'd4);

        // Random stalls, wait states and branches
        for (int i = 0; i < 3000; i++) begin
            k  = int'($urandom_range(0, 16)) - 8;
            bt = if_id_valid && ($urandom_range(0, 5) == 0);
            step(bt, 32'(k), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
        end
        repeat (4) step(1'b0, 32'd0, 1'b0, 1'b1);
        n_checks++;
        if (n_deliv < 500) begin
            n_fail++;
            $display("FAIL deliveries: got %0d expected at least 500", n_deliv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
